xor_checksum_arbiter: RTL and testbench

Shares one rotating XOR-checksum datapath between NUM_REQ requesters. Each checksum bit is a 3-input XOR of the accumulator bit, its rotated neighbour and the data bit. A round-robin arbiter grants one requester at a time and accepts its word burst over a valid/ready handshake. The final checksum is presented on a held-valid result port. The block sits between packet sources and the link-integrity logic in the fabric design.

---
 rtl/xor_checksum_pkg.sv | 46 ++++
 rtl/xor_checksum_arbiter_rr_arbiter.sv | 40 ++++
 rtl/xor_checksum_arbiter.sv | 145 ++++++++++++++
 tb/tb_xor_checksum_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_checksum_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : xor_checksum_pkg
// Purpose  : Shared types, width helpers and checksum step functions for
//            the xor_checksum_arbiter block.
// Revision : 1.0 - initial release
// ============================================================================
package xor_checksum_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

  // Widest checksum the helper functions handle; callers zero-extend into it
  localparam int MAX_W = 64;

  // Requester index width (at least one bit)
  function automatic int id_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  // Word counter width, able to hold max_len itself
  function automatic int cnt_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Rotate left by one within the low w bits
  function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] mask;
    mask = (w >= MAX_W) ? {MAX_W{1'b1}} : ((64'd1 << w) - 64'd1);
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

  // One checksum step: each bit XORs itself, its lower neighbour and data
  function automatic logic [MAX_W-1:0] xor3_step(input logic [MAX_W-1:0] acc,
                                                 input logic [MAX_W-1:0] din,
                                                 input int               w);
    return acc ^ rotl1(acc, w) ^ din;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xor_checksum_arbiter_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick: first set request bit found
//            searching upward from the pointer, with wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] cand;

  // Scan from the farthest offset down so the nearest request wins last
  always_comb begin
    valid = 1'b0;
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (req[cand]) begin
        valid     = 1'b1;
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/xor_checksum_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : xor_checksum_arbiter
// Purpose  : Round-robin shares one rotating XOR checksum datapath between
//            NUM_REQ burst sources; results leave on a held-valid port.
// Revision : 1.0 - initial release
// ============================================================================
module xor_checksum_arbiter
  import xor_checksum_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 16
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [NUM_REQ-1:0]                  REQ,
  output logic [NUM_REQ-1:0]                  GNT,
  input  logic [NUM_REQ*DATA_W-1:0]           DIN,
  input  logic [NUM_REQ-1:0]                  DIN_VALID,
  input  logic [NUM_REQ-1:0]                  DIN_LAST,
  output logic [NUM_REQ-1:0]                  DIN_READY,
  output logic [DATA_W-1:0]                   SUM,
  output logic [id_width(NUM_REQ)-1:0]        SUM_ID,
  output logic [cnt_width(MAX_LEN)-1:0]       SUM_CNT,
  output logic                                SUM_ERR,
  output logic                                SUM_VALID,
  input  logic                                SUM_READY
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = cnt_width(MAX_LEN);

  state_t              state;
  state_t              state_nxt;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     ptr_nxt;
  logic [ID_W-1:0]     gidx;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   acc_next;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic [DATA_W-1:0]   din_g;
  logic                valid_g;
  logic                last_g;
  logic                accept;
  logic                at_max;
  logic                burst_end;
  logic                arb_valid;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]     arb_idx;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req   (REQ),
    .ptr   (ptr),
    .valid (arb_valid),
    .gnt   (arb_gnt),
    .idx   (arb_idx)
  );

  // Granted lane selection and checksum/count next values
  always_comb begin
    din_g     = DIN[gidx*DATA_W +: DATA_W];
    valid_g   = DIN_VALID[gidx];
    last_g    = DIN_LAST[gidx];
    DIN_READY = (state == ACCUM) ? GNT : '0;
    accept    = valid_g & DIN_READY[gidx];
    acc_next  = DATA_W'(xor3_step(MAX_W'(acc), MAX_W'(din_g), DATA_W));
    cnt_next  = cnt + CNT_W'(1);
    at_max    = (cnt_next == CNT_W'(MAX_LEN));
    burst_end = accept & (last_g | at_max);
    ptr_nxt   = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + ID_W'(1);
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_valid) state_nxt = ACCUM;
      ACCUM:   if (burst_end) state_nxt = RESULT;
      RESULT:  if (SUM_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grant, accumulator, result and pointer registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      GNT       <= '0;
      gidx      <= '0;
      ptr       <= '0;
      acc       <= '0;
      cnt       <= '0;
      SUM       <= '0;
      SUM_ID    <= '0;
      SUM_CNT   <= '0;
      SUM_ERR   <= 1'b0;
      SUM_VALID <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            GNT  <= arb_gnt;
            gidx <= arb_idx;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt_next;
          end
          if (burst_end) begin
            GNT       <= '0;
            SUM       <= acc_next;
            SUM_ID    <= gidx;
            SUM_CNT   <= cnt_next;
            SUM_ERR   <= ~last_g;
            SUM_VALID <= 1'b1;
          end
        end
        RESULT: begin
          if (SUM_READY) begin
            SUM_VALID <= 1'b0;
            ptr       <= ptr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xor_checksum_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_xor_checksum_arbiter
// Purpose  : Directed self-checking bench with expected-result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xor_checksum_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  REQ;
  logic [3:0]  GNT;
  logic [31:0] DIN;
  logic [3:0]  DIN_VALID;
  logic [3:0]  DIN_LAST;
  logic [3:0]  DIN_READY;
  logic [7:0]  SUM;
  logic [1:0]  SUM_ID;
  logic [4:0]  SUM_CNT;
  logic        SUM_ERR;
  logic        SUM_VALID;
  logic        SUM_READY;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] sum;
    logic [1:0] id;
    logic [4:0] cnt;
    logic       err;
  } exp_t;

  exp_t sb[$];

  xor_checksum_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ       (REQ),
    .GNT       (GNT),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .DIN_LAST  (DIN_LAST),
    .DIN_READY (DIN_READY),
    .SUM       (SUM),
    .SUM_ID    (SUM_ID),
    .SUM_CNT   (SUM_CNT),
    .SUM_ERR   (SUM_ERR),
    .SUM_VALID (SUM_VALID),
    .SUM_READY (SUM_READY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference checksum step written bit-wise from the definition
  function automatic logic [7:0] model_step(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = a[b] ^ a[(b + 7) % 8] ^ d[b];
    return r;
  endfunction

  function automatic logic [7:0] word_of(input logic [7:0] base, input logic [7:0] inc, input int k);
    return base + 8'(k) * inc;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_grant(input int exp_id);
    int n;
    n = 0;
    while (GNT == 4'b0 && n < 40) begin
      tick();
      n++;
    end
    chk("grant", 32'(GNT), 32'(1) << exp_id);
  endtask

  // Push the expected result, then feed up to n words while the lane is ready.
  // Other lanes present valid+last with random data, which must be ignored.
  task automatic send_burst(input int id, input int n, input bit with_last,
                            input logic [7:0] base, input logic [7:0] inc);
    exp_t       e;
    int         exp_cnt;
    int         acc_n;
    logic [7:0] a;
    exp_cnt = (n > MAX_LEN) ? MAX_LEN : n;
    a = 8'h00;
    for (int k = 0; k < exp_cnt; k++) a = model_step(a, word_of(base, inc, k));
    e.sum = a;
    e.id  = 2'(id);
    e.cnt = 5'(exp_cnt);
    e.err = (n > MAX_LEN) || (!with_last && n == MAX_LEN);
    sb.push_back(e);
    acc_n = 0;
    for (int k = 0; k < n; k++) begin
      if (k == 0) chk("ready_onehot", 32'(DIN_READY), 32'(1) << id);
      if (!DIN_READY[id]) break;
      DIN           = $urandom;
      DIN[id*8 +: 8] = word_of(base, inc, k);
      DIN_VALID     = 4'hF;
      DIN_LAST      = 4'hF;
      DIN_LAST[id]  = with_last && (k == n - 1);
      tick();
      acc_n++;
    end
    DIN_VALID = 4'h0;
    DIN_LAST  = 4'h0;
    chk("accepted_words", acc_n, exp_cnt);
  endtask

  task automatic check_result(output exp_t e);
    int n;
    n = 0;
    while (!SUM_VALID && n < 40) begin
      tick();
      n++;
    end
    chk("sum_valid", 32'(SUM_VALID), 32'(1));
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{sum: 8'h00, id: 2'd0, cnt: 5'd0, err: 1'b0};
    chk("sum",      32'(SUM),     32'(e.sum));
    chk("sum_id",   32'(SUM_ID),  32'(e.id));
    chk("sum_cnt",  32'(SUM_CNT), 32'(e.cnt));
    chk("sum_err",  32'(SUM_ERR), 32'(e.err));
    chk("gnt_in_result", 32'(GNT), 32'(0));
  endtask

  task automatic consume();
    SUM_READY = 1'b1;
    tick();
    chk("sum_valid_clear", 32'(SUM_VALID), 32'(0));
  endtask

  initial begin
    exp_t e;
    RST       = 1'b1;
    REQ       = 4'h0;
    DIN       = 32'h0;
    DIN_VALID = 4'h0;
    DIN_LAST  = 4'h0;
    SUM_READY = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_gnt",   32'(GNT),       32'(0));
    chk("rst_ready", 32'(DIN_READY), 32'(0));
    chk("rst_sum",   32'(SUM),       32'(0));
    chk("rst_valid", 32'(SUM_VALID), 32'(0));
    RST = 1'b0;
    tick();

    // Single-word burst from requester 0, grant latency of one cycle
    REQ = 4'b0001;
    tick();
    chk("grant_latency", 32'(GNT), 32'(4'b0001));
    REQ = 4'b0000;
    send_burst(0, 1, 1'b1, 8'hA5, 8'h00);
    check_result(e);
    chk("single_sum_const", 32'(SUM), 32'(8'hA5));
    consume();

    // Two-word burst from requester 2: 0x01, 0x01
    REQ = 4'b0100;
    wait_grant(2);
    REQ = 4'b0000;
    send_burst(2, 2, 1'b1, 8'h01, 8'h00);
    check_result(e);
    chk("two_word_const", 32'(SUM), 32'(8'h02));
    consume();

    // Fairness with all requests held; pointer sits at 3 after requester 2
    REQ = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_grant((3 + j) % 4);
      send_burst((3 + j) % 4, 1, 1'b1, 8'h10 + 8'(j), 8'h00);
      check_result(e);
      consume();
    end

    // Backpressure: result held stable, no new grant until accepted
    SUM_READY = 1'b0;
    wait_grant(0);
    send_burst(0, 3, 1'b1, 8'h5A, 8'h03);
    check_result(e);
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("bp_valid", 32'(SUM_VALID), 32'(1));
      chk("bp_sum",   32'(SUM),       32'(e.sum));
      chk("bp_id",    32'(SUM_ID),    32'(e.id));
      chk("bp_cnt",   32'(SUM_CNT),   32'(e.cnt));
      chk("bp_gnt",   32'(GNT),       32'(0));
    end
    consume();

    // Truncation: 20 words without LAST from requester 1
    REQ = 4'b0010;
    wait_grant(1);
    REQ = 4'b0000;
    send_burst(1, 20, 1'b0, 8'h33, 8'h07);
    check_result(e);
    chk("trunc_cnt_const", 32'(SUM_CNT), 32'(16));
    chk("trunc_err_const", 32'(SUM_ERR), 32'(1));
    consume();

    // Reset after three accepted words from requester 3
    REQ = 4'b1000;
    wait_grant(3);
    REQ = 4'b0000;
    DIN_VALID = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      DIN[24 +: 8] = 8'h71 + 8'(k);
      tick();
    end
    #2;
    RST = 1'b1;
    #1;
    chk("arst_gnt",   32'(GNT),       32'(0));
    chk("arst_ready", 32'(DIN_READY), 32'(0));
    chk("arst_sum",   32'(SUM),       32'(0));
    chk("arst_id",    32'(SUM_ID),    32'(0));
    chk("arst_cnt",   32'(SUM_CNT),   32'(0));
    chk("arst_err",   32'(SUM_ERR),   32'(0));
    chk("arst_valid", 32'(SUM_VALID), 32'(0));
    DIN_VALID = 4'h0;
    tick();
    RST = 1'b0;
    tick();

    // Pointer restarts at 0: with requesters 1 and 3 pending, 1 wins
    REQ = 4'b1010;
    wait_grant(1);
    REQ = 4'b0000;
    send_burst(1, 1, 1'b1, 8'h3C, 8'h00);
    check_result(e);
    chk("post_rst_sum_const", 32'(SUM), 32'(8'h3C));
    consume();

    // Next grant follows the advanced pointer
    REQ = 4'b1111;
    wait_grant(2);
    REQ = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
